mac_scheduler: RTL

Sequences the PE's per-lane FIFO pops and MAC enables for one accumulation run. It sits between the system control logic and the PE. On `start` it clears the selected accumulators, pops each enabled lane's FIFO exactly `mac_len` times as data becomes available, and asserts one MAC per pop. It then holds a result-valid flag until the consumer acknowledges. It replaces the hard-wired `rd_en`/`mac_en` inputs currently driven from the top level.

---
 rtl/nnfc_pkg.sv | 21 ++
 rtl/lane_seq.sv | 49 ++++
 rtl/mac_scheduler.sv | 112 +++++++++++
 3 files changed

// File: rtl/nnfc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nnfc_pkg
// Description : Shared types and sizing constants for the NN feature core.
// Revision    : 1.0 - initial release
// ============================================================================
package nnfc_pkg;

    localparam int NNFC_LANES     = 4;
    localparam int NNFC_MAC_CNT_W = 10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        HOLD  = 3'd4
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/lane_seq.sv
`default_nettype none
// ============================================================================
// Module      : lane_seq
// Description : Per-lane pop down-counter, FIFO pop and delayed MAC enable.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_seq
    import nnfc_pkg::*;
#(
    parameter int CNT_W = NNFC_MAC_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_run,
    input  logic             i_empty,
    input  logic             i_clear,
    output logic             o_rd_en,
    output logic             o_mac_en,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_mac_en;

    assign o_zero   = (r_cnt == '0);
    assign o_rd_en  = i_run & ~i_empty & ~o_zero;
    assign o_mac_en = r_mac_en;

    // MAC follows the pop by one cycle to match the FIFO read latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_mac_en <= 1'b0;
        end else begin
            r_mac_en <= o_rd_en & ~i_clear;
            if (i_clear) begin
                r_cnt <= '0;
            end else if (i_load) begin
                r_cnt <= i_load_val;
            end else if (o_rd_en) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mac_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : mac_scheduler
// Description : Sequences per-lane FIFO pops and MAC enables for one
//               accumulation run, then holds results until acknowledged.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_scheduler
    import nnfc_pkg::*;
#(
    parameter int LANES = NNFC_LANES,
    parameter int CNT_W = NNFC_MAC_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] mac_len,
    input  logic [LANES-1:0] lane_mask,
    input  logic [LANES-1:0] empty,
    input  logic             res_ack,
    output logic [LANES-1:0] rd_en,
    output logic [LANES-1:0] mac_en,
    output logic [LANES-1:0] acc_clr,
    output logic             busy,
    output logic             res_valid,
    output logic             done
);

    sched_state_t     r_state;
    sched_state_t     w_next_state;
    logic [LANES-1:0] r_mask_q;
    logic [LANES-1:0] r_acc_clr;
    logic             r_res_valid;
    logic             r_done;
    logic [LANES-1:0] w_zero;
    logic             w_accept;
    logic             w_abort;
    logic             w_run;
    logic             w_all_zero;

    assign w_accept   = (r_state == IDLE) & start;
    assign w_abort    = abort & (r_state != IDLE);
    assign w_run      = (r_state == RUN) & ~abort;
    assign w_all_zero = &w_zero;

    assign acc_clr   = r_acc_clr;
    assign busy      = (r_state != IDLE);
    assign res_valid = r_res_valid;
    assign done      = r_done;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            lane_seq #(
                .CNT_W (CNT_W)
            ) u_lane_seq (
                .clk        (clk),
                .rst        (rst),
                .i_load     (w_accept),
                .i_load_val (lane_mask[gi] ? mac_len : '0),
                .i_run      (w_run & r_mask_q[gi]),
                .i_empty    (empty[gi]),
                .i_clear    (w_abort),
                .o_rd_en    (rd_en[gi]),
                .o_mac_en   (mac_en[gi]),
                .o_zero     (w_zero[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Abort overrides every other transition, including the HOLD ack.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = CLEAR;
            CLEAR:   w_next_state = RUN;
            RUN:     if (w_all_zero) w_next_state = DRAIN;
            DRAIN:   w_next_state = HOLD;
            HOLD:    if (res_ack) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
        if (w_abort) begin
            w_next_state = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mask_q    <= '0;
            r_acc_clr   <= '0;
            r_res_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mask_q <= lane_mask;
            end
            r_acc_clr   <= w_accept ? lane_mask : '0;
            r_res_valid <= (w_next_state == HOLD);
            r_done      <= (r_state == HOLD) & res_ack & ~w_abort;
        end
    end

endmodule
`default_nettype wire
